// File: rtl/rk8e_break_bridge.sv
// rtl/rk8e_break_bridge.sv - RK8-E disk data-break bridge; optional break timeout via BRK_TIMEOUT_EN
module rk8e_break_bridge #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [4:0] DB1_STATE  = 5'd20,
    parameter logic [4:0] DB2_STATE  = 5'd21,
    parameter int         TMO_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_dma_req,
    input  logic        i_dma_wr,
    input  logic [14:0] i_dma_addr,
    input  logic [11:0] i_dma_wdata,
    output logic        o_dma_gnt,
    output logic        o_dma_done,
    output logic [11:0] o_dma_rdata,
    input  logic [4:0]  i_state,
    input  logic        i_break_in_prog,
    input  logic [11:0] i_mem_rdata,
    output logic        o_data_break,
    output logic [14:0] o_break_addr,
    output logic        o_break_to_mem,
    output logic [11:0] o_break_wdata,
    output logic [8:0]  o_word_count,
    output logic        o_brk_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DB   = 2'd2
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_next;

    // Queue entry layout: {wr, addr[14:0], wdata[11:0]}
    logic [27:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [27:0]      w_head;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_complete;
    logic             w_tmo_expired;
    logic             w_unused;

    logic             r_dma_gnt;
    logic             r_dma_done;
    logic [11:0]      r_dma_rdata;
    logic             r_data_break;
    logic [14:0]      r_break_addr;
    logic             r_break_to_mem;
    logic [11:0]      r_break_wdata;
    logic [8:0]       r_word_count;

    // break_in_prog is informative only; the CPU state bus drives the handshake
    assign w_unused = i_break_in_prog | (TMO_CYCLES == 0);

    assign w_head = r_fifo[r_rd_ptr];
    assign w_full = (r_count == FULL_CNT);
    // Full check uses pre-pop occupancy; the gnt cycle itself never pushes so a
    // still-high request is not queued twice.
    assign w_push = i_dma_req & ~r_dma_gnt & ~w_full;

    // Queue storage; contents are qualified by r_count so no reset is needed
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {i_dma_wr, i_dma_addr, i_dma_wdata};
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Break FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fsm <= S_IDLE;
        end else if (i_clear) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Break FSM next state: IDLE loads the head, REQ waits for DB1, DB waits for DB2
    always_comb begin
        w_fsm_next = r_fsm;
        w_load     = 1'b0;
        w_pop      = 1'b0;
        w_complete = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                // DB1 seen here belongs to some other break master and is ignored
                if (r_count != '0) begin
                    w_load     = 1'b1;
                    w_fsm_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_state == DB1_STATE) begin
                    w_fsm_next = S_DB;
                end else if (w_tmo_expired) begin
                    w_pop      = 1'b1;
                    w_fsm_next = S_IDLE;
                end
            end
            S_DB: begin
                if (i_state == DB2_STATE) begin
                    w_pop      = 1'b1;
                    w_complete = 1'b1;
                    w_fsm_next = S_IDLE;
                end
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // Registered disk handshake, CPU break request and word counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dma_gnt      <= 1'b0;
            r_dma_done     <= 1'b0;
            r_dma_rdata    <= '0;
            r_data_break   <= 1'b0;
            r_break_addr   <= '0;
            r_break_to_mem <= 1'b0;
            r_break_wdata  <= '0;
            r_word_count   <= '0;
        end else if (i_clear) begin
            r_dma_gnt      <= 1'b0;
            r_dma_done     <= 1'b0;
            r_dma_rdata    <= '0;
            r_data_break   <= 1'b0;
            r_break_addr   <= '0;
            r_break_to_mem <= 1'b0;
            r_break_wdata  <= '0;
            r_word_count   <= '0;
        end else begin
            r_dma_gnt  <= w_push;
            r_dma_done <= w_complete;
            if (w_load) begin
                r_data_break   <= 1'b1;
                r_break_to_mem <= w_head[27];
                r_break_addr   <= w_head[26:12];
                r_break_wdata  <= w_head[11:0];
            end else if (r_fsm == S_REQ && w_fsm_next != S_REQ) begin
                // Address and data stay put through DB2; only the request drops
                r_data_break <= 1'b0;
            end
            if (w_complete) begin
                r_word_count <= r_word_count + 9'd1;
                if (!r_break_to_mem) begin
                    r_dma_rdata <= i_mem_rdata;
                end
            end
        end
    end

`ifdef BRK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_brk_err;

    assign w_tmo_expired = (r_tmo_cnt == TMO_LAST);

    // Cycles the current head has waited in REQ for the CPU to enter DB1
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tmo_cnt <= '0;
        end else if (i_clear) begin
            r_tmo_cnt <= '0;
        end else if (r_fsm == S_REQ && w_fsm_next == S_REQ) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Sticky error: the only REQ->IDLE exit is a timeout drop of the head
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_brk_err <= 1'b0;
        end else if (i_clear) begin
            r_brk_err <= 1'b0;
        end else if (r_fsm == S_REQ && w_fsm_next == S_IDLE) begin
            r_brk_err <= 1'b1;
        end
    end

    assign o_brk_err = r_brk_err;
`else
    assign w_tmo_expired = 1'b0;
    assign o_brk_err     = 1'b0;
`endif

    assign o_dma_gnt      = r_dma_gnt;
    assign o_dma_done     = r_dma_done;
    assign o_dma_rdata    = r_dma_rdata;
    assign o_data_break   = r_data_break;
    assign o_break_addr   = r_break_addr;
    assign o_break_to_mem = r_break_to_mem;
    assign o_break_wdata  = r_break_wdata;
    assign o_word_count   = r_word_count;

endmodule
